// File: rtl/tx_engine.sv
// tx_engine: UART 8N1 transmit engine, LSB first, OSR ticks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP.
module tx_engine #(
  parameter int OSR = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       osr_tick_i,
  input  logic [7:0] tx_fifo_data_i,
  input  logic       tx_fifo_empty_i,
  output logic       tx_fifo_ren_o,
  input  logic       tx_en_i,
  output logic       transmit_bit_o,
  output logic       tx_busy_o
);
  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] TMAX = TW'(OSR - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic line_q, line_d, busy_q, busy_d, last;
  assign last = osr_tick_i && tick_q == TMAX;
  assign transmit_bit_o = line_q;
  assign tx_busy_o = busy_q;
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    tx_fifo_ren_o = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == IDLE) begin
      tick_d = '0;
      bit_d = '0;
      if (tx_en_i && !tx_fifo_empty_i && !reset_i) begin
        tx_fifo_ren_o = 1'b1;
        shift_d = tx_fifo_data_i;
        state_d = START;
`ifdef UART_TX_PARITY_EN
        par_d = ^tx_fifo_data_i;
`endif
      end
    end else if (osr_tick_i) begin
      tick_d = last ? '0 : tick_q + 1'b1;
    end
    if (last) begin
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          bit_d = bit_q + 3'd1;
          shift_d = shift_q >> 1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
        PARITY: state_d = STOP;
`endif
        STOP: state_d = IDLE;
        default: ;
      endcase
    end
    // line is registered from the next state so it changes on the bit-ending edge
`ifdef UART_TX_PARITY_EN
    line_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_q : 1'b1;
`else
    line_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      line_q <= 1'b1;
      busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      line_q <= line_d;
      busy_q <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_tx_engine.sv
// tb_tx_engine: scoreboard bench; expected frames queued by stimulus, checked by a line monitor.
module tb_tx_engine;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, reset_i = 1'b1, osr_tick_i = 1'b0;
  logic [7:0] tx_fifo_data_i = 8'h00;
  logic tx_fifo_empty_i = 1'b1, tx_en_i = 1'b0;
  logic tx_fifo_ren_o, transmit_bit_o, tx_busy_o;
  int checks = 0, errors = 0;
  logic [7:0] fifo[$];
  logic [10:0] exp_q[$];
  int ren_cnt = 0, ren_bad = 0;
  int cyc = 0, frames = 0, busy_ticks = 0, end_cyc = 0, gap = 0, tcnt = 0;
  logic active = 1'b0, bad = 1'b0, post = 1'b0;
  logic [3:0] bitn = 4'd0;
  logic [10:0] cur = '0;

  tx_engine #(.OSR(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .osr_tick_i(osr_tick_i),
    .tx_fifo_data_i(tx_fifo_data_i), .tx_fifo_empty_i(tx_fifo_empty_i),
    .tx_fifo_ren_o(tx_fifo_ren_o), .tx_en_i(tx_en_i),
    .transmit_bit_o(transmit_bit_o), .tx_busy_o(tx_busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #2;
      c = (c == 10) ? 0 : c + 1;
      osr_tick_i = (c == 0);
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p);
    logic [10:0] f;
    f = {1'b1, p, d, 1'b0};
`ifndef UART_TX_PARITY_EN
    f = {1'b0, 1'b1, d, 1'b0};
`endif
    return f;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (osr_tick_i && tx_busy_o) busy_ticks++;
      if (reset_i) begin
        active = 1'b0;
        post = 1'b0;
      end else begin
        if (post) begin
          post = 1'b0;
          chk("busy_fall", int'(tx_busy_o), 0);
          chk("line_idle_after_stop", int'(transmit_bit_o), 1);
        end
        if (!active && transmit_bit_o == 1'b0) begin
          chk("frame_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            active = 1'b1;
            bitn = 4'd0;
            tcnt = 0;
            bad = 1'b0;
            gap = cyc - end_cyc;
          end
        end
        if (active) begin
          if (transmit_bit_o !== cur[bitn] || tx_busy_o !== 1'b1) bad = 1'b1;
          if (osr_tick_i) tcnt++;
          if (tcnt == 16) begin
            chk($sformatf("frame_bit%0d_bad", bitn), int'(bad), 0);
            bitn = bitn + 4'd1;
            tcnt = 0;
            bad = 1'b0;
            if (int'(bitn) == NB) begin
              active = 1'b0;
              frames++;
              end_cyc = cyc;
              post = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic step();
    logic pend;
    #1;
    pend = tx_fifo_ren_o;
    if (pend) begin
      ren_cnt++;
      if (tx_fifo_empty_i) ren_bad++;
    end
    @(posedge clk);
    #1;
    if (pend && fifo.size() > 0) void'(fifo.pop_front());
    tx_fifo_empty_i = fifo.size() == 0;
    tx_fifo_data_i = fifo.size() > 0 ? fifo[0] : 8'h00;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic p);
    fifo.push_back(d);
    exp_q.push_back(frame(d, p));
  endtask

  task automatic wait_frames(input int n);
    int f0 = frames;
    for (int i = 0; i < 2000 * n + 200 && frames < f0 + n; i++) step();
    chk("frames_done", frames - f0, n);
    repeat (2) step();
  endtask

  task automatic wait_bit(input int k);
    for (int i = 0; i < 4000 && !(active && int'(bitn) == k); i++) step();
    chk("reach_bit", int'(active && int'(bitn) == k), 1);
  endtask

  initial begin
    int r0, bt0, viol;
    repeat (3) step();
    chk("rst_line", int'(transmit_bit_o), 1);
    chk("rst_busy", int'(tx_busy_o), 0);
    chk("rst_ren", int'(tx_fifo_ren_o), 0);
    reset_i = 1'b0;
    step();
    // single byte
    r0 = ren_cnt;
    bt0 = busy_ticks;
    send(8'hA5, 1'b0);
    tx_en_i = 1'b1;
    wait_frames(1);
    chk("single_ren", ren_cnt - r0, 1);
    chk("single_busy_ticks", busy_ticks - bt0, NB * 16);
    // back-to-back
    r0 = ren_cnt;
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    wait_frames(2);
    chk("b2b_gap", gap, 2);
    chk("b2b_ren", ren_cnt - r0, 2);
    // disabled
    tx_en_i = 1'b0;
    r0 = ren_cnt;
    viol = 0;
    fifo.push_back(8'h5A);
    repeat (500) begin
      step();
      if (transmit_bit_o !== 1'b1 || tx_busy_o !== 1'b0) viol++;
    end
    chk("dis_violations", viol, 0);
    chk("dis_ren", ren_cnt - r0, 0);
    exp_q.push_back(frame(8'h5A, 1'b0));
    tx_en_i = 1'b1;
    step();
    chk("en_start_line", int'(transmit_bit_o), 0);
    chk("en_start_busy", int'(tx_busy_o), 1);
    wait_frames(1);
    // enable drop mid-frame
    r0 = ren_cnt;
    send(8'h3C, 1'b0);
    fifo.push_back(8'h55);
    wait_bit(4);
    tx_en_i = 1'b0;
    wait_frames(1);
    repeat (100) step();
    chk("drop_ren", ren_cnt - r0, 1);
    chk("drop_fifo_left", fifo.size(), 1);
    chk("drop_line", int'(transmit_bit_o), 1);
    chk("drop_busy", int'(tx_busy_o), 0);
    fifo.delete();
    step();
    // reset mid-frame
    tx_en_i = 1'b1;
    send(8'hF0, 1'b0);
    wait_bit(6);
    r0 = ren_cnt;
    reset_i = 1'b1;
    step();
    chk("rstmid_line", int'(transmit_bit_o), 1);
    chk("rstmid_busy", int'(tx_busy_o), 0);
    step();
    reset_i = 1'b0;
    repeat (20) step();
    chk("rstmid_ren", ren_cnt - r0, 0);
    chk("rstmid_line_idle", int'(transmit_bit_o), 1);
    r0 = ren_cnt;
    send(8'h81, 1'b0);
    wait_frames(1);
    chk("after_rst_ren", ren_cnt - r0, 1);
`ifdef UART_TX_PARITY_EN
    bt0 = busy_ticks;
    send(8'h07, 1'b1);
    send(8'h03, 1'b0);
    wait_frames(2);
    chk("par_busy_ticks", busy_ticks - bt0, 2 * 176);
`endif
    chk("ren_while_empty", ren_bad, 0);
    chk("exp_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
